viterbi_seq: RTL and testbench
==============================

VITERBI_SEQ -- requirements
Module: viterbi_seq

Interface
REQ-001 SHALL have parameter WD_FSM, default 6, meaning ACSSegment width; segments per page NSEG = 2^WD_FSM.
REQ-002 SHALL have parameter WD_DEPTH, default 5, meaning ACSPage width; traceback window NPAGE = 2^WD_DEPTH pages.
REQ-003 SHALL have port CLOCK, input, 1, the single system clock; all logic rises on it.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port Active, input, 1; high = symbol data available, low = stall request.
REQ-006 SHALL have port FrameStart, input, 1, single-cycle pulse that starts or restarts a frame.
REQ-007 SHALL have port Flush, input, 1, single-cycle pulse marking frame end.
REQ-008 SHALL have port ACSSegment, output, WD_FSM, current ACS segment index.
REQ-009 SHALL have port ACSPage, output, WD_DEPTH, current survivor-memory page.
REQ-010 SHALL have ports Ph1En and Ph2En, outputs, 1 each; these are clock enables for ACS phase 1 and phase 2, replacing divided clocks.
REQ-011 SHALL have ports Init, Hold, CompareStart, TB_EN, TB_Last and Busy, outputs, 1 each.

Function
REQ-012 SHALL implement the states IDLE, INIT, RUN and DRAIN.
REQ-013 IDLE: the block SHALL hold all outputs low; FrameStart moves it to INIT.
REQ-014 INIT: lasts exactly 1 cycle; ACSSegment, ACSPage, the phase flag and CompareStart are cleared to 0; Init = 1; the next state is RUN.
REQ-015 RUN with Active = 1: the phase flag SHALL toggle every cycle; Ph1En = 1 on phase 0 and Ph2En = 1 on phase 1; these outputs are combinational from the state and phase, so exactly one of them is high per non-stalled cycle.
REQ-016 On each Ph2En cycle, ACSSegment SHALL increment by 1; it wraps from NSEG-1 to 0, and on that wrap ACSPage increments modulo NPAGE.
REQ-017 RUN with Active = 0: the phase flag and the counters freeze, Ph1En = Ph2En = 0, and Hold = 1; Hold is 0 in all other states.
REQ-018 Init SHALL stay high from the INIT cycle through the Ph2En cycle of segment NSEG-1 on page 0 of the frame; this is the first full sweep.
REQ-019 CompareStart SHALL be set on the first ACSPage wrap from NPAGE-1 to 0 after INIT, and it stays set until INIT, IDLE or Reset.
REQ-020 TB_EN SHALL pulse for 1 cycle, coincident with the Ph2En cycle of segment NSEG-1, while CompareStart is already set; this gives one traceback per page.
REQ-021 A Flush received in RUN SHALL be latched, even if Active = 0, and taken at the next page boundary: after the Ph2En cycle of segment NSEG-1 the block enters DRAIN.
REQ-022 DRAIN: lasts exactly 1 cycle; TB_EN = 1 and TB_Last = 1 regardless of CompareStart; Ph1En = Ph2En = 0; the next state is IDLE.
REQ-023 TB_Last SHALL be 1 only in DRAIN.
REQ-024 Busy SHALL be 1 in INIT, RUN and DRAIN.
REQ-025 FrameStart has priority over everything. In any state, FrameStart goes to INIT, discards a latched Flush, and aborts any TB_EN that cycle. When it coincides with Flush, FrameStart wins.
REQ-026 Flush in IDLE, INIT or DRAIN SHALL be ignored.
REQ-027 A second Flush while one is already latched SHALL have no additional effect.

Reset
REQ-028 Reset = 1 SHALL immediately, without a clock edge, force state IDLE, ACSSegment = 0, ACSPage = 0, clear the phase flag and the Flush latch, and drive Ph1En, Ph2En, Init, Hold, CompareStart, TB_EN, TB_Last and Busy to 0.
REQ-029 After Reset is released, the block SHALL stay in IDLE until FrameStart, including when Reset was asserted mid-RUN or mid-DRAIN.

Verification
Bench parameters: WD_FSM = 2, WD_DEPTH = 2, so NSEG = 4 and NPAGE = 4; one page = 8 RUN cycles.
REQ-030 Basic sweep: Reset, then FrameStart, then Active = 1 for 40 cycles. Required: Init high for 9 cycles (INIT plus 8); ACSSegment runs 0..3 with the page advancing every 8 cycles; CompareStart rises after 32 RUN cycles; the first TB_EN comes at RUN cycle 40, on page 0, segment 3.
REQ-031 Stall: drop Active for 5 cycles at segment 2, phase 1. Required: Hold = 1 for 5 cycles, ACSSegment = 2 frozen, no Ph1En/Ph2En pulses, and the run resumes with Ph2En.
REQ-032 Flush mid-page: Flush at page 1, segment 1. Required: the remainder of page 1 runs, then 1 DRAIN cycle with TB_EN = TB_Last = 1, then IDLE with Busy = 0.
REQ-033 Collision: FrameStart and Flush in the same cycle during RUN. Required: INIT next cycle, counters = 0, no DRAIN, Init = 1.
REQ-034 Async reset: assert Reset mid-RUN between clock edges. Required: all outputs 0 before the next edge, and the block stays IDLE after release until FrameStart.
REQ-035 Short frame: Flush at page 0, segment 2. Required: DRAIN follows segment 3; TB_Last = 1 while CompareStart = 0; no earlier TB_EN.

Source files
------------

// File: rtl/viterbi_seq.sv
// Viterbi ACS/traceback sequencer: IDLE/INIT/RUN/DRAIN FSM driving phase enables, segment/page counters and traceback strobes.
// Outputs are combinational from registered state (zero latency); Active low stalls the counters and raises Hold.
module viterbi_seq #(
  parameter int WD_FSM   = 6,
  parameter int WD_DEPTH = 5
) (
  input  logic                CLOCK,
  input  logic                Reset,
  input  logic                Active,
  input  logic                FrameStart,
  input  logic                Flush,
  output logic [WD_FSM-1:0]   ACSSegment,
  output logic [WD_DEPTH-1:0] ACSPage,
  output logic                Ph1En,
  output logic                Ph2En,
  output logic                Init,
  output logic                Hold,
  output logic                CompareStart,
  output logic                TB_EN,
  output logic                TB_Last,
  output logic                Busy
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DRAIN} state_t;

  localparam logic [WD_FSM-1:0]   SEG_MAX  = '1;
  localparam logic [WD_DEPTH-1:0] PAGE_MAX = '1;

  state_t              state, state_nxt;
  logic [WD_FSM-1:0]   seg;
  logic [WD_DEPTH-1:0] page;
  logic                phase;
  logic                flush_lat;
  logic                cmp_start;
  logic                init_r;
  logic                seg_last;

  assign seg_last   = (seg == SEG_MAX);
  assign ACSSegment = seg;
  assign ACSPage    = page;

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    Ph1En        = 1'b0;
    Ph2En        = 1'b0;
    Init         = 1'b0;
    Hold         = 1'b0;
    CompareStart = 1'b0;
    TB_EN        = 1'b0;
    TB_Last      = 1'b0;
    Busy         = 1'b0;
    case (state)
      IDLE: begin
        if (FrameStart) state_nxt = INIT;
      end
      INIT: begin
        Init      = 1'b1;
        Busy      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        Busy         = 1'b1;
        Hold         = ~Active;
        Ph1En        = Active & ~phase;
        Ph2En        = Active & phase;
        Init         = init_r;
        CompareStart = cmp_start;
        TB_EN        = Ph2En & seg_last & cmp_start;
        // A flush arriving on the page-closing cycle itself is honoured immediately.
        if (Ph2En && seg_last && (flush_lat || Flush)) state_nxt = DRAIN;
      end
      DRAIN: begin
        Busy         = 1'b1;
        TB_EN        = 1'b1;
        TB_Last      = 1'b1;
        CompareStart = cmp_start;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // FrameStart overrides everything, including a traceback due this cycle.
    if (FrameStart) begin
      state_nxt = INIT;
      TB_EN     = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      seg       <= '0;
      page      <= '0;
      phase     <= 1'b0;
      flush_lat <= 1'b0;
      cmp_start <= 1'b0;
      init_r    <= 1'b0;
    end else if (FrameStart) begin
      seg       <= '0;
      page      <= '0;
      phase     <= 1'b0;
      flush_lat <= 1'b0;
      cmp_start <= 1'b0;
      init_r    <= 1'b1;
    end else begin
      case (state)
        INIT: init_r <= 1'b1;
        RUN: begin
          if (Flush) flush_lat <= 1'b1;
          if (Active) begin
            phase <= ~phase;
            if (phase) begin
              seg <= seg + WD_FSM'(1);
              if (seg_last) begin
                page <= page + WD_DEPTH'(1);
                if (page == PAGE_MAX) cmp_start <= 1'b1;
                if (page == '0)       init_r    <= 1'b0;
              end
            end
          end
        end
        default: begin
          seg       <= '0;
          page      <= '0;
          phase     <= 1'b0;
          flush_lat <= 1'b0;
          cmp_start <= 1'b0;
          init_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_seq.sv
// Directed bench for viterbi_seq with NSEG = 4, NPAGE = 4 (8 RUN cycles per page).
module tb_viterbi_seq;

  logic       CLOCK = 1'b0;
  logic       Reset, Active, FrameStart, Flush;
  logic [1:0] ACSSegment, ACSPage;
  logic       Ph1En, Ph2En, Init, Hold, CompareStart, TB_EN, TB_Last, Busy;

  int ntests = 0;
  int nfail  = 0;
  int rk     = 0;

  always #5 CLOCK = ~CLOCK;

  viterbi_seq #(.WD_FSM(2), .WD_DEPTH(2)) dut (
    .CLOCK(CLOCK), .Reset(Reset), .Active(Active), .FrameStart(FrameStart), .Flush(Flush),
    .ACSSegment(ACSSegment), .ACSPage(ACSPage), .Ph1En(Ph1En), .Ph2En(Ph2En),
    .Init(Init), .Hold(Hold), .CompareStart(CompareStart), .TB_EN(TB_EN),
    .TB_Last(TB_Last), .Busy(Busy)
  );

  // Bit order: Ph1En Ph2En Init Hold CompareStart TB_EN TB_Last Busy | segment | page
  localparam logic [11:0] ALL_ZERO = 12'h000;
  localparam logic [11:0] CNT_MASK = 12'hFF0;
  localparam logic [11:0] TB_MASK  = 12'h040;

  function automatic logic [11:0] obs();
    return {Ph1En, Ph2En, Init, Hold, CompareStart, TB_EN, TB_Last, Busy, ACSSegment, ACSPage};
  endfunction

  function automatic logic [11:0] pack(bit p1, bit p2, bit ini, bit hold, bit cmp, bit tb,
                                       bit last, bit busy, int seg, int pg);
    logic [1:0] s, p;
    s = seg[1:0];
    p = pg[1:0];
    return {p1, p2, ini, hold, cmp, tb, last, busy, s, p};
  endfunction

  // Expected outputs for RUN cycle k (1-based within the frame).
  function automatic logic [11:0] exp_run(int k, bit stalled);
    int  ph, seg, pg;
    bit  cmp;
    ph  = (k - 1) % 2;
    seg = ((k - 1) / 2) % 4;
    pg  = ((k - 1) / 8) % 4;
    cmp = (k >= 33);
    if (stalled) return pack(0, 0, k <= 8, 1, cmp, 0, 0, 1, seg, pg);
    return pack(ph == 0, ph == 1, k <= 8, 0, cmp, (k % 8 == 0) && cmp, 0, 1, seg, pg);
  endfunction

  task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] e);
    ntests++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: observed=%03h expected=%03h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #2;
  endtask

  task automatic run_step(input string tag, input bit stalled);
    Active = !stalled;
    #1;
    chk(tag, obs(), exp_run(rk + 1, stalled));
    tick();
    if (!stalled) rk++;
  endtask

  initial begin
    Reset = 1'b1; Active = 1'b0; FrameStart = 1'b0; Flush = 1'b0;
    #1;
    chk("reset_state", obs(), ALL_ZERO);
    tick(); tick();
    Reset = 1'b0; Active = 1'b1;
    #1; chk("idle_after_reset", obs(), ALL_ZERO);
    tick();
    #1; chk("idle_stays", obs(), ALL_ZERO);

    // Basic sweep, stall, resume
    FrameStart = 1'b1;
    #1; chk("idle_fs_cycle", obs(), ALL_ZERO);
    tick(); FrameStart = 1'b0;
    #1; chk("init", obs(), pack(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    tick(); rk = 0;
    repeat (45) run_step("sweep", 0);
    repeat (5)  run_step("stall", 1);
    repeat (10) run_step("resume", 0);

    // Collision on a traceback cycle (k=56: page 2, segment 3)
    FrameStart = 1'b1; Flush = 1'b1; Active = 1'b1;
    #1; chk("collide_tb_abort", obs(), exp_run(56, 0) & ~TB_MASK);
    tick(); FrameStart = 1'b0; Flush = 1'b0;
    #1; chk("collide_init", obs(), pack(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    tick(); rk = 0;

    // Flush mid-page 1, plus a redundant flush during a stall
    repeat (10) run_step("pre_flush", 0);
    Flush = 1'b1; run_step("flush_mid", 0); Flush = 1'b0;
    run_step("flush_pending", 0);
    Flush = 1'b1; run_step("flush_again_stall", 1); Flush = 1'b0;
    repeat (4) run_step("flush_page_rest", 0);
    Active = 1'b1;
    #1; chk("drain", obs() & CNT_MASK, pack(0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    tick();
    #1; chk("idle_after_drain", obs(), ALL_ZERO);
    Flush = 1'b1; tick(); Flush = 1'b0;
    #1; chk("idle_flush_ignored", obs(), ALL_ZERO);

    // Short frame: flush at page 0 segment 2
    FrameStart = 1'b1; tick(); FrameStart = 1'b0;
    #1; chk("short_init", obs(), pack(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    tick(); rk = 0;
    repeat (4) run_step("short_run", 0);
    Flush = 1'b1; run_step("short_flush", 0); Flush = 1'b0;
    repeat (3) run_step("short_rest", 0);
    #1; chk("short_drain", obs() & CNT_MASK, pack(0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    tick();
    #1; chk("short_idle", obs(), ALL_ZERO);

    // Asynchronous reset between edges mid-RUN
    FrameStart = 1'b1; tick(); FrameStart = 1'b0;
    tick(); rk = 0;
    repeat (5) run_step("pre_reset_run", 0);
    Reset = 1'b1;
    #1; chk("async_reset", obs(), ALL_ZERO);
    tick(); Reset = 1'b0; Active = 1'b1;
    repeat (3) begin
      #1; chk("idle_post_reset", obs(), ALL_ZERO);
      tick();
    end
    FrameStart = 1'b1; tick(); FrameStart = 1'b0;
    #1; chk("restart_init", obs(), pack(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
